// File: rtl/mpu_issue_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : mpu_issue_dispatch
// Brief    : Stamps sequencer instructions with a wrapping issue number,
//            broadcasts them to the enabled TPUs with per-lane handshakes,
//            registers each issue with the commit aggregator and throttles
//            on aggregator-full / outstanding-issue limit.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_issue_dispatch #(
   parameter int NUM_TPU         = 1,
   parameter int WIDTH_ISSUE     = 8,
   parameter int WIDTH_INSTR     = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   I_Req,
   input  logic [WIDTH_INSTR-1:0]                 I_Instr,
   input  logic [NUM_TPU-1:0]                     I_En_TPU,
   output logic                                   O_Ack,
   output logic [NUM_TPU-1:0]                     O_TPU_Req,
   output logic [WIDTH_INSTR-1:0]                 O_TPU_Instr,
   output logic [WIDTH_ISSUE-1:0]                 O_TPU_Issue_No,
   input  logic [NUM_TPU-1:0]                     I_TPU_Rdy,
   output logic                                   O_Agg_Req,
   output logic [WIDTH_ISSUE-1:0]                 O_Agg_Issue_No,
   output logic [NUM_TPU-1:0]                     O_Agg_En_TPU,
   input  logic                                   I_Agg_Full,
   input  logic                                   I_Commit_Req,
   input  logic [WIDTH_ISSUE-1:0]                 I_Commit_No,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   O_Num_Out,
   output logic                                   O_Busy,
   output logic                                   O_Err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BCAST = 1'b1
   } state_t;

   state_t                 state;
   logic [WIDTH_ISSUE-1:0] issue_cnt;     // next issue number to hand out
   logic [WIDTH_ISSUE-1:0] exp_commit;    // issue number the next commit must carry
   logic [WIDTH_ISSUE-1:0] issue_no;      // issue number of the current/last instruction
   logic [WIDTH_INSTR-1:0] instr_q;
   logic [NUM_TPU-1:0]     en_q;
   logic [NUM_TPU-1:0]     done;
   logic [CNT_W-1:0]       num_out;
   logic                   agg_req;
   logic                   err;

   logic                   accept;
   logic [NUM_TPU-1:0]     lane_req;
   logic [NUM_TPU-1:0]     done_next;
   logic                   all_done;
   logic                   commit_dec;

   // Accept decision, lane requests and broadcast completion. Accept is
   // gated by reset so no ack can escape while reset is held.
   always_comb begin
      accept     = reset & (state == IDLE) & I_Req & (|I_En_TPU) & ~I_Agg_Full
                   & (num_out < MAX_CNT);
      lane_req   = (state == BCAST) ? (en_q & ~done) : '0;
      done_next  = done | (lane_req & I_TPU_Rdy);
      all_done   = ((done_next & en_q) == en_q);
      commit_dec = I_Commit_Req & (num_out != '0);
   end

   // Issue FSM, counters, outstanding tracking and sticky error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         issue_cnt  <= '0;
         exp_commit <= '0;
         issue_no   <= '0;
         instr_q    <= '0;
         en_q       <= '0;
         done       <= '0;
         num_out    <= '0;
         agg_req    <= 1'b0;
         err        <= 1'b0;
      end else begin
         agg_req <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  instr_q   <= I_Instr;
                  en_q      <= I_En_TPU;
                  issue_no  <= issue_cnt;
                  issue_cnt <= issue_cnt + WIDTH_ISSUE'(1);
                  done      <= '0;
                  agg_req   <= 1'b1;
                  state     <= BCAST;
               end else if (I_Req && (I_En_TPU == '0)) begin
                  // Empty target mask is a sequencer bug: flag and drop.
                  err <= 1'b1;
               end
            end
            BCAST: begin
               done <= done_next;
               if (all_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Simultaneous accept and commit cancel out.
         if (accept && !commit_dec) begin
            num_out <= num_out + CNT_W'(1);
         end else if (!accept && commit_dec) begin
            num_out <= num_out - CNT_W'(1);
         end

         // Commits must arrive in issue order; a stray or out-of-order one
         // is flagged but still consumed so tracking stays aligned.
         if (I_Commit_Req) begin
            exp_commit <= exp_commit + WIDTH_ISSUE'(1);
            if ((num_out == '0) || (I_Commit_No != exp_commit)) begin
               err <= 1'b1;
            end
         end
      end
   end

   assign O_Ack          = accept;
   assign O_TPU_Req      = lane_req;
   assign O_TPU_Instr    = instr_q;
   assign O_TPU_Issue_No = issue_no;
   assign O_Agg_Req      = agg_req;
   assign O_Agg_Issue_No = issue_no;
   assign O_Agg_En_TPU   = en_q;
   assign O_Num_Out      = num_out;
   assign O_Busy         = (state == BCAST) | (num_out != '0);
   assign O_Err          = err;

endmodule
`default_nettype wire
